seq_multiplier: RTL and testbench

Multi-cycle unsigned shift-add multiplier for the RISC datapath. It is the inverse companion to the combinational divider and produces the low or high word of an A×B product. It sits beside the ALU/divider and accepts one operation per start handshake. It reports completion with a one-cycle done pulse and holds the selected result word until the next completion.

---
 rtl/mul_pkg.sv | 19 +
 rtl/mul_step.sv | 21 ++
 rtl/seq_multiplier.sv | 117 +++++++++++
 tb/tb_seq_multiplier.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// MUL_EARLY_TERM_EN (see seq_multiplier) changes only latency, never these definitions.
package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = $clog2(MUL_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mul_step.sv
// One combinational add-shift iteration of the unsigned multiplier.
// Also flags when the shifted multiplier has run out of set bits.
module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplr,
    output logic [2*WIDTH-1:0] prod_nxt,
    output logic [2*WIDTH-1:0] mcand_nxt,
    output logic [WIDTH-1:0]   mplr_nxt,
    output logic               mplr_zero
);

    // The running sum never exceeds A*B, so the add cannot carry out.
    assign prod_nxt  = mplr[0] ? (prod + mcand) : prod;
    assign mcand_nxt = mcand << 1;
    assign mplr_nxt  = mplr >> 1;
    assign mplr_zero = (mplr_nxt == '0);

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-add multiplier returning the low or high product word.
// Define MUL_EARLY_TERM_EN to leave RUN as soon as the multiplier is exhausted.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             isMul,
    input  logic             isMulh,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       state_dbg
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t               state;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplr;
    logic [CW-1:0]        count;
    logic [1:0]           sel;
    logic                 mplr_zero_q;
    logic                 finish;

    logic [2*WIDTH-1:0]   prod_nxt;
    logic [2*WIDTH-1:0]   mcand_nxt;
    logic [WIDTH-1:0]     mplr_nxt;
    logic                 mplr_zero;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .prod      (prod),
        .mcand     (mcand),
        .mplr      (mplr),
        .prod_nxt  (prod_nxt),
        .mcand_nxt (mcand_nxt),
        .mplr_nxt  (mplr_nxt),
        .mplr_zero (mplr_zero)
    );

`ifdef MUL_EARLY_TERM_EN
    assign finish = mplr_zero_q || (count == LAST);
`else
    assign finish = (count == LAST);
`endif

    // Handshake: an operation is accepted on a rising edge where start=1 and
    // busy=0; busy stays high through the done cycle, and start is ignored meanwhile.
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prod        <= '0;
            mcand       <= '0;
            mplr        <= '0;
            count       <= '0;
            sel         <= '0;
            mplr_zero_q <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand       <= {{WIDTH{1'b0}}, A};
                        mplr        <= B;
                        prod        <= '0;
                        count       <= '0;
                        sel         <= {isMul, isMulh};
                        mplr_zero_q <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (finish) begin
                        done  <= 1'b1;
                        state <= DONE;
                        if (sel[1])
                            result <= prod[WIDTH-1:0];
                        else if (sel[0])
                            result <= prod[2*WIDTH-1:WIDTH];
                        else
                            result <= '0;
                    end else begin
                        // Once the multiplier is exhausted further steps cannot change prod.
                        if (!mplr_zero_q) begin
                            prod        <= prod_nxt;
                            mcand       <= mcand_nxt;
                            mplr        <= mplr_nxt;
                            mplr_zero_q <= mplr_zero;
                        end
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (fixed or early-terminating build).
module tb_seq_multiplier;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         is_mul = 1'b0;
    logic         is_mulh = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [1:0]   state_dbg;

    int           n_tests = 0;
    int           n_fail = 0;
    logic [W-1:0] exp_q[$];

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (a),
        .B         (b),
        .isMul     (is_mul),
        .isMulh    (is_mulh),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // driver: issue one operation, then check latency, pulse shape and result
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic m, input logic mh, input logic [W-1:0] expv);
        int           cycles;
        int           lat;
        logic         seen;
        logic [W-1:0] e;
        lat = W + 1;
`ifdef MUL_EARLY_TERM_EN
        lat = 1;
        for (int i = 0; i < W; i++)
            if (tb_v[i]) lat = i + 1;
        lat = lat + 1;
`endif
        exp_q.push_back(expv);
        @(negedge clk);
        a = ta; b = tb_v; is_mul = m; is_mulh = mh; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        is_mul = 1'($urandom_range(0, 1)); is_mulh = 1'($urandom_range(0, 1));
        check({tag, "_busy_after_accept"}, W'(busy), W'(1));
        cycles = 0;
        seen = 1'b0;
        while (cycles < 200 && !seen) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, W'(seen), W'(1));
        check({tag, "_latency"}, W'(cycles), W'(lat));
        e = exp_q.pop_front();
        check({tag, "_result"}, result, e);
        check({tag, "_busy_in_done"}, W'(busy), W'(1));
        @(posedge clk);
        #1;
        check({tag, "_done_single"}, W'(done), W'(0));
        check({tag, "_busy_fall"}, W'(busy), W'(0));
        check({tag, "_result_hold"}, result, e);
    endtask

    initial begin
        int dones;

        #12;
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_result", result, W'(0));
        check("reset_state", W'(state_dbg), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7x6", 32'd7, 32'd6, 1'b1, 1'b0, 32'h0000_002A);
        repeat (3) @(negedge clk);
        check("hold_idle_7x6", result, 32'h0000_002A);
        run_op("mulh_7x6", 32'd7, 32'd6, 1'b0, 1'b1, 32'h0000_0000);
        run_op("mulh_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFE);
        run_op("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0001);
        run_op("both_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0001);
        run_op("mulh_8000x2", 32'h8000_0000, 32'd2, 1'b0, 1'b1, 32'h0000_0001);
        run_op("mul_1234x100", 32'h0000_1234, 32'h0000_0100, 1'b1, 1'b0, 32'h0012_3400);
        run_op("none_bzero", 32'h1234_5678, 32'd0, 1'b0, 1'b0, 32'h0000_0000);
        run_op("mul_ff_to_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0001);

        // start while busy must be ignored
        @(negedge clk);
        a = 32'd3; b = 32'd5; is_mul = 1'b1; is_mulh = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("busy_ignore_done_count", W'(dones), W'(1));
        check("busy_ignore_result", result, 32'd15);
        check("busy_ignore_idle", W'(busy), W'(0));

        // reset in the middle of RUN
        @(negedge clk);
        a = 32'h0000_1234; b = 32'hFFFF_FFFF; is_mul = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", W'(busy), W'(0));
        check("async_reset_done", W'(done), W'(0));
        check("async_reset_result", result, W'(0));
        check("async_reset_state", W'(state_dbg), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) check("no_done_after_reset", W'(done), W'(0));
        end
        run_op("post_reset_2x3", 32'd2, 32'd3, 1'b1, 1'b0, 32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
